force_sched: RTL and testbench

Cycle-scheduled force/release driver for forceable nets in regression benches. Commands (start cycle, duration, bit mask, value) are queued in a small FIFO and applied as a per-bit override on a W-bit net. Outside a force window the net passes through unmodified. This is the driving end of force-observation tests: the block forces and releases, and an observer checks the result against the free-running cycle counter it also exports.

---
 rtl/force_sched_pkg.sv | 21 ++
 rtl/force_sched_fifo.sv | 52 +++++
 rtl/force_sched.sv | 168 ++++++++++++++++
 tb/tb_force_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/force_sched_pkg.sv
// Shared types for the force/release scheduler: the command record layout
// (at the default widths) and the scheduler FSM states.
package force_sched_pkg;

    localparam int DEF_W  = 9;
    localparam int DEF_CW = 32;

    typedef struct packed {
        logic [DEF_CW-1:0] start;
        logic [7:0]        len;
        logic [DEF_W-1:0]  en;
        logic [DEF_W-1:0]  val;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } state_t;

endpackage

// File: rtl/force_sched_fifo.sv
// Synchronous command FIFO with full/empty flags. The element type defaults to
// cmd_t and is overridden by the top level to match its width parameters.
module force_sched_fifo
    import force_sched_pkg::*;
#(
    parameter type T     = cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; an entry is only read
    // after it has been written, so clearing it would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/force_sched.sv
// Cycle-scheduled force/release driver: queued commands overlay a per-bit value
// onto net_in for a window of cycles. FORCE_SCHED_LATE_CNT_EN adds late_cnt.
module force_sched
    import force_sched_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [CW-1:0] cmd_start,
    input  logic [7:0]    cmd_len,
    input  logic [W-1:0]  cmd_en,
    input  logic [W-1:0]  cmd_val,
    input  logic [W-1:0]  net_in,
    output logic [W-1:0]  net_out,
    output logic [CW-1:0] cyc,
    output logic          forcing,
    output logic          busy,
    output logic          late
`ifdef FORCE_SCHED_LATE_CNT_EN
    ,
    output logic [7:0]    late_cnt
`endif
);

    typedef struct packed {
        logic [CW-1:0] start;
        logic [7:0]    len;
        logic [W-1:0]  en;
        logic [W-1:0]  val;
    } cmd_rec_t;

    cmd_rec_t      push_cmd;
    cmd_rec_t      head;
    cmd_rec_t      pend;
    cmd_rec_t      src;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    state_t        state;
    state_t        state_nxt;
    logic [7:0]    remaining;
    logic          hold;
    logic [W-1:0]  ovr_en;
    logic [W-1:0]  ovr_val;
    logic          load;
    logic          clear;
    logic          late_nxt;
    logic [CW-1:0] cyc_next;

    assign push_cmd.start = cmd_start;
    assign push_cmd.len   = cmd_len;
    assign push_cmd.en    = cmd_en;
    assign push_cmd.val   = cmd_val;

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    force_sched_fifo #(
        .T     (cmd_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign cyc_next = cyc + CW'(1);

    // IDLE inspects the FIFO head directly so a command that is already due
    // loads on the popping edge; only future starts park in WAIT.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        late_nxt  = 1'b0;
        src       = pend;
        case (state)
            IDLE: begin
                src = head;
                if (!empty) begin
                    pop = 1'b1;
                    if (head.start == cyc_next) begin
                        load = 1'b1;
                    end else if (head.start <= cyc) begin
                        load     = 1'b1;
                        late_nxt = 1'b1;
                    end
                    state_nxt = load ? FORCE : WAIT;
                end
            end
            WAIT: begin
                if (pend.start == cyc_next) begin
                    load      = 1'b1;
                    state_nxt = FORCE;
                end
            end
            FORCE: begin
                if (hold ? !empty : (remaining == 8'd1)) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc       <= '0;
            late      <= 1'b0;
            pend      <= '0;
            ovr_en    <= '0;
            ovr_val   <= '0;
            remaining <= '0;
            hold      <= 1'b0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_next;
            late  <= late_nxt;
            if (pop) begin
                pend <= head;
            end
            if (load) begin
                ovr_en    <= src.en;
                ovr_val   <= src.val;
                remaining <= src.len;
                hold      <= (src.len == 8'd0);
            end else if (clear) begin
                ovr_en  <= '0;
                ovr_val <= '0;
            end else if (state == FORCE && !hold) begin
                remaining <= remaining - 8'd1;
            end
        end
    end

`ifdef FORCE_SCHED_LATE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            late_cnt <= '0;
        end else if (late_nxt && late_cnt != 8'hFF) begin
            late_cnt <= late_cnt + 8'd1;
        end
    end
`endif

    assign net_out = (net_in & ~ovr_en) | (ovr_val & ovr_en);
    assign forcing = (state == FORCE);
    assign busy    = !empty || (state != IDLE);

endmodule

// File: tb/tb_force_sched.sv
// Directed bench for force_sched: a per-cycle vector table for the basic
// windows, then hand-written sequences for late, back-to-back, full and reset.
module tb_force_sched;

    localparam int W  = 9;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_start;
    logic [7:0]    cmd_len;
    logic [W-1:0]  cmd_en;
    logic [W-1:0]  cmd_val;
    logic [W-1:0]  net_in;
    logic [W-1:0]  net_out;
    logic [CW-1:0] cyc;
    logic          forcing;
    logic          busy;
    logic          late;
`ifdef FORCE_SCHED_LATE_CNT_EN
    logic [7:0]    late_cnt;
`endif

    force_sched #(.W(W), .DEPTH(4), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_en    (cmd_en),
        .cmd_val   (cmd_val),
        .net_in    (net_in),
        .net_out   (net_out),
        .cyc       (cyc),
        .forcing   (forcing),
        .busy      (busy),
        .late      (late)
`ifdef FORCE_SCHED_LATE_CNT_EN
        ,
        .late_cnt  (late_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int tc    = 0;

    typedef struct {
        bit            rst;
        bit            valid;
        logic [CW-1:0] start;
        logic [7:0]    len;
        logic [W-1:0]  en;
        logic [W-1:0]  val;
        logic [W-1:0]  ni;
        logic [CW-1:0] e_cyc;
        logic [W-1:0]  e_out;
        bit            e_forcing;
        bit            e_late;
        bit            e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input bit r, input bit v, input logic [CW-1:0] st, input logic [7:0] ln,
                       input logic [W-1:0] en, input logic [W-1:0] val, input logic [W-1:0] ni,
                       input logic [CW-1:0] ec, input logic [W-1:0] eo,
                       input bit ef, input bit el, input bit eb);
        vec_t x;
        x.rst = r; x.valid = v; x.start = st; x.len = ln; x.en = en; x.val = val; x.ni = ni;
        x.e_cyc = ec; x.e_out = eo; x.e_forcing = ef; x.e_late = el; x.e_busy = eb;
        tbl.push_back(x);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        tc++;
    endtask

    task automatic at(input int c);
        while (tc < c) next();
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        next();
        rst_n = 1'b1;
        tc    = 0;
    endtask

    task automatic push(input logic [CW-1:0] st, input logic [7:0] ln,
                        input logic [W-1:0] en, input logic [W-1:0] val);
        cmd_valid = 1'b1;
        cmd_start = st;
        cmd_len   = ln;
        cmd_en    = en;
        cmd_val   = val;
        next();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bb_out [9:15];
        bit           bb_frc [9:15];
        bit           bb_lat [9:15];

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_len = '0;
        cmd_en = '0; cmd_val = '0; net_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single force {4,2,1FF,0BE} pushed at cyc 1, then reset, then partial mask.
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h123, 0, 9'h123, 0, 0, 0);
        add(0, 1, 4, 2, 9'h1FF, 9'h0BE, 9'h0F0, 1, 9'h0F0, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1FF, 2, 9'h1FF, 0, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h000, 3, 9'h000, 0, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h155, 4, 9'h0BE, 1, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h0AA, 5, 9'h0BE, 1, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h101, 6, 9'h101, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h0BE, 7, 9'h0BE, 0, 0, 0);
        add(1, 0, 0, 0, 9'h000, 9'h000, 9'h03C, 8, 9'h03C, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1FF, 0, 9'h1FF, 0, 0, 0);
        add(0, 1, 6, 3, 9'h001, 9'h001, 9'h1FE, 1, 9'h1FE, 0, 0, 0);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1FD, 2, 9'h1FD, 0, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1FC, 3, 9'h1FC, 0, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1FB, 4, 9'h1FB, 0, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1FA, 5, 9'h1FA, 0, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1F9, 6, 9'h1F9, 1, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1F8, 7, 9'h1F9, 1, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1F7, 8, 9'h1F7, 1, 0, 1);
        add(0, 0, 0, 0, 9'h000, 9'h000, 9'h1F6, 9, 9'h1F6, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n     = !tbl[i].rst;
            cmd_valid = tbl[i].valid;
            cmd_start = tbl[i].start;
            cmd_len   = tbl[i].len;
            cmd_en    = tbl[i].en;
            cmd_val   = tbl[i].val;
            net_in    = tbl[i].ni;
            probe();
            check($sformatf("row%0d cyc", i), cyc, tbl[i].e_cyc);
            check($sformatf("row%0d net_out", i), net_out, tbl[i].e_out);
            check($sformatf("row%0d forcing", i), forcing, tbl[i].e_forcing);
            check($sformatf("row%0d late", i), late, tbl[i].e_late);
            check($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
            check($sformatf("row%0d cmd_ready", i), cmd_ready, 1);
            next();
        end
        rst_n     = 1'b1;
        cmd_valid = 1'b0;

        // Late command: start=2 pushed at cyc 10, overlay exactly at cyc 12.
        reset_dut();
        net_in = 9'h1AA;
        at(10);
        push(2, 1, 9'h1FF, 9'h055);
        probe();
        check("late c11 late", late, 0);
        check("late c11 forcing", forcing, 0);
        next(); probe();
        check("late c12 net_out", net_out, 9'h055);
        check("late c12 late", late, 1);
        check("late c12 forcing", forcing, 1);
`ifdef FORCE_SCHED_LATE_CNT_EN
        check("late c12 late_cnt", late_cnt, 1);
`endif
        next(); probe();
        check("late c13 net_out", net_out, 9'h1AA);
        check("late c13 late", late, 0);
        check("late c13 forcing", forcing, 0);

        // Back-to-back: second start falls in the release gap.
        reset_dut();
        net_in = 9'h000;
        push(10, 2, 9'h1FF, 9'h0F0);
        push(12, 2, 9'h1FF, 9'h10F);
        bb_out = '{9'h000, 9'h0F0, 9'h0F0, 9'h000, 9'h10F, 9'h10F, 9'h000};
        bb_frc = '{0, 1, 1, 0, 1, 1, 0};
        bb_lat = '{0, 0, 0, 0, 1, 0, 0};
        for (int c = 9; c <= 15; c++) begin
            at(c); probe();
            check($sformatf("b2b c%0d net_out", c), net_out, bb_out[c]);
            check($sformatf("b2b c%0d forcing", c), forcing, bb_frc[c]);
            check($sformatf("b2b c%0d late", c), late, bb_lat[c]);
        end
`ifdef FORCE_SCHED_LATE_CNT_EN
        check("b2b late_cnt", late_cnt, 1);
`endif

        // len=0 hold, released by the next command; that one has en=0 and is late.
        reset_dut();
        net_in = 9'h0C3;
        at(1);
        push(3, 0, 9'h1FF, 9'h1E1);
        at(3); probe();
        check("hold c3 net_out", net_out, 9'h1E1);
        check("hold c3 late", late, 0);
        at(6); probe();
        check("hold c6 forcing", forcing, 1);
        push(8, 1, 9'h000, 9'h1FF);
        probe();
        check("hold c7 net_out", net_out, 9'h1E1);
        next(); probe();
        check("hold c8 forcing", forcing, 0);
        check("hold c8 net_out", net_out, 9'h0C3);
        next(); probe();
        check("noop c9 forcing", forcing, 1);
        check("noop c9 late", late, 1);
        check("noop c9 net_out", net_out, 9'h0C3);
        next(); probe();
        check("noop c10 busy", busy, 0);

        // FIFO full: A waits in WAIT while four more fill the FIFO.
        reset_dut();
        net_in = 9'h000;
        push(20, 1, 9'h1FF, 9'h155);
        for (int k = 1; k <= 4; k++) begin
            probe();
            check($sformatf("full c%0d cmd_ready", k), cmd_ready, 1);
            push(CW'(2000 + k), 1, 9'h1FF, 9'h001);
        end
        probe();
        check("full c5 cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_start = 3000;
        cmd_len   = 1;
        cmd_en    = 9'h1FF;
        cmd_val   = 9'h002;
        at(20); probe();
        check("full c20 net_out", net_out, 9'h155);
        check("full c20 cmd_ready", cmd_ready, 0);
        next(); probe();
        check("full c21 cmd_ready (pop, no bypass)", cmd_ready, 0);
        next(); probe();
        check("full c22 cmd_ready", cmd_ready, 1);
        next(); probe();
        check("full c23 cmd_ready", cmd_ready, 0);
        check("full c23 busy", busy, 1);
        cmd_valid = 1'b0;

        // Reset mid-force.
        reset_dut();
        net_in = 9'h0F0;
        at(1);
        push(4, 8, 9'h1FF, 9'h0AA);
        at(4); probe();
        check("rst c4 net_out", net_out, 9'h0AA);
        next(); probe();
        check("rst c5 forcing", forcing, 1);
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        probe();
        check("rst after cyc", cyc, 0);
        check("rst after forcing", forcing, 0);
        check("rst after busy", busy, 0);
        check("rst after net_out", net_out, 9'h0F0);
        check("rst after cmd_ready", cmd_ready, 1);
`ifdef FORCE_SCHED_LATE_CNT_EN
        check("rst after late_cnt", late_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
